// File: rtl/hoplite_packet_tx_controller_if.sv
// Signal bundle between the CPU MMIO side / Hoplite router injection port and the TX controller.
// master = host/router side, slave = controller side.
interface hoplite_packet_tx_controller_if #(
   parameter int unsigned COORD_BITS     = 1,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned FIFO_ADDR_BITS = 3
);
   logic [COORD_BITS-1:0]   x_coord_in;
   logic                    x_coord_in_valid;
   logic [COORD_BITS-1:0]   y_coord_in;
   logic                    y_coord_in_valid;
   logic [DATA_WIDTH-1:0]   message_in;
   logic                    message_in_valid;
   logic                    packet_complete;
   logic                    error_clear;
   logic [COORD_BITS-1:0]   flit_out_x;
   logic [COORD_BITS-1:0]   flit_out_y;
   logic [DATA_WIDTH-1:0]   flit_out_data;
   logic                    flit_out_last;
   logic                    flit_out_valid;
   logic                    flit_out_ready;
   logic                    tx_busy;
   logic                    packet_sent;
   logic                    tx_error;
   logic [FIFO_ADDR_BITS:0] fifo_count;

   modport master (
      output x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid,
             message_in, message_in_valid, packet_complete, error_clear,
             flit_out_ready,
      input  flit_out_x, flit_out_y, flit_out_data, flit_out_last, flit_out_valid,
             tx_busy, packet_sent, tx_error, fifo_count
   );

   modport slave (
      input  x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid,
             message_in, message_in_valid, packet_complete, error_clear,
             flit_out_ready,
      output flit_out_x, flit_out_y, flit_out_data, flit_out_last, flit_out_valid,
             tx_busy, packet_sent, tx_error, fifo_count
   );
endinterface

// File: rtl/hoplite_packet_tx_controller.sv
// Buffers MMIO payload words and, on packet-complete, drains them as flits into the
// local Hoplite router injection port; reports busy / sent / sticky error status.
module hoplite_packet_tx_controller #(
   parameter int unsigned COORD_BITS     = 1,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned FIFO_ADDR_BITS = 3
) (
   input  logic                          clk,
   input  logic                          reset_n,
   hoplite_packet_tx_controller_if.slave bus
);

   localparam int unsigned CNT_BITS = FIFO_ADDR_BITS + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;

   logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
   logic [FIFO_ADDR_BITS-1:0] r_wr_ptr;
   logic [FIFO_ADDR_BITS-1:0] r_rd_ptr;
   logic [CNT_BITS-1:0]       r_count;
   logic [COORD_BITS-1:0]     r_dest_x;
   logic [COORD_BITS-1:0]     r_dest_y;
   logic [COORD_BITS-1:0]     r_send_x;
   logic [COORD_BITS-1:0]     r_send_y;
   logic                      r_flit_valid;
   logic [DATA_WIDTH-1:0]     r_flit_data;
   logic                      r_flit_last;
   logic [COORD_BITS-1:0]     r_flit_x;
   logic [COORD_BITS-1:0]     r_flit_y;
   logic                      r_busy;
   logic                      r_sent;
   logic                      r_error;

   logic                      w_full;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_err_set;
   logic [FIFO_ADDR_BITS-1:0] w_wr_ptr_nxt;
   logic [FIFO_ADDR_BITS-1:0] w_rd_ptr_nxt;
   logic [CNT_BITS-1:0]       w_count_nxt;
   logic [COORD_BITS-1:0]     w_dest_x_nxt;
   logic [COORD_BITS-1:0]     w_dest_y_nxt;
   logic [COORD_BITS-1:0]     w_send_x_nxt;
   logic [COORD_BITS-1:0]     w_send_y_nxt;
   logic [DATA_WIDTH-1:0]     w_head_nxt;
   logic                      w_flit_valid_nxt;
   logic [DATA_WIDTH-1:0]     w_flit_data_nxt;
   logic                      w_flit_last_nxt;
   logic [COORD_BITS-1:0]     w_flit_x_nxt;
   logic [COORD_BITS-1:0]     w_flit_y_nxt;
   logic                      w_busy_nxt;
   logic                      w_sent_nxt;
   logic                      w_error_nxt;

   // Next-state, FIFO control and registered-output precomputation
   always_comb begin
      w_state_nxt  = r_state;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_err_set    = 1'b0;
      w_dest_x_nxt = r_dest_x;
      w_dest_y_nxt = r_dest_y;
      w_send_x_nxt = r_send_x;
      w_send_y_nxt = r_send_y;
      w_full       = (r_count == CNT_BITS'(FIFO_DEPTH));

      unique case (r_state)
         ST_IDLE: begin
            if (bus.x_coord_in_valid) w_dest_x_nxt = bus.x_coord_in;
            if (bus.y_coord_in_valid) w_dest_y_nxt = bus.y_coord_in;
            if (bus.message_in_valid) begin
               if (w_full) w_err_set = 1'b1;
               else        w_push    = 1'b1;
            end
            // The same-cycle word and coordinates are part of the packet being closed
            if (bus.packet_complete && ((r_count != '0) || w_push)) begin
               w_send_x_nxt = w_dest_x_nxt;
               w_send_y_nxt = w_dest_y_nxt;
               w_state_nxt  = ST_SEND;
            end
         end
         ST_SEND: begin
            w_err_set = bus.x_coord_in_valid | bus.y_coord_in_valid | bus.message_in_valid;
            if (r_flit_valid && bus.flit_out_ready) begin
               w_pop = 1'b1;
               if (r_count == CNT_BITS'(1)) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_err_set   = bus.x_coord_in_valid | bus.y_coord_in_valid | bus.message_in_valid;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      w_wr_ptr_nxt = r_wr_ptr + FIFO_ADDR_BITS'(w_push);
      w_rd_ptr_nxt = r_rd_ptr + FIFO_ADDR_BITS'(w_pop);
      w_count_nxt  = r_count + CNT_BITS'(w_push) - CNT_BITS'(w_pop);

      // A word pushed into an empty FIFO is not in the array yet; forward it
      w_head_nxt = (w_push && (r_count == '0)) ? bus.message_in : r_mem[w_rd_ptr_nxt];

      w_flit_valid_nxt = (w_state_nxt == ST_SEND);
      w_flit_data_nxt  = w_flit_valid_nxt ? w_head_nxt : '0;
      w_flit_last_nxt  = w_flit_valid_nxt && (w_count_nxt == CNT_BITS'(1));
      w_flit_x_nxt     = w_flit_valid_nxt ? w_send_x_nxt : '0;
      w_flit_y_nxt     = w_flit_valid_nxt ? w_send_y_nxt : '0;
      w_busy_nxt       = (w_state_nxt != ST_IDLE);
      w_sent_nxt       = (w_state_nxt == ST_DONE);
      // A new error beats a simultaneous clear
      w_error_nxt      = w_err_set | (r_error & ~bus.error_clear);
   end

   // State, pointers and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_dest_x     <= '0;
         r_dest_y     <= '0;
         r_send_x     <= '0;
         r_send_y     <= '0;
         r_flit_valid <= 1'b0;
         r_flit_data  <= '0;
         r_flit_last  <= 1'b0;
         r_flit_x     <= '0;
         r_flit_y     <= '0;
         r_busy       <= 1'b0;
         r_sent       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_ptr     <= w_wr_ptr_nxt;
         r_rd_ptr     <= w_rd_ptr_nxt;
         r_count      <= w_count_nxt;
         r_dest_x     <= w_dest_x_nxt;
         r_dest_y     <= w_dest_y_nxt;
         r_send_x     <= w_send_x_nxt;
         r_send_y     <= w_send_y_nxt;
         r_flit_valid <= w_flit_valid_nxt;
         r_flit_data  <= w_flit_data_nxt;
         r_flit_last  <= w_flit_last_nxt;
         r_flit_x     <= w_flit_x_nxt;
         r_flit_y     <= w_flit_y_nxt;
         r_busy       <= w_busy_nxt;
         r_sent       <= w_sent_nxt;
         r_error      <= w_error_nxt;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (reset_n && w_push) r_mem[r_wr_ptr] <= bus.message_in;
   end

   assign bus.flit_out_valid = r_flit_valid;
   assign bus.flit_out_data  = r_flit_data;
   assign bus.flit_out_last  = r_flit_last;
   assign bus.flit_out_x     = r_flit_x;
   assign bus.flit_out_y     = r_flit_y;
   assign bus.tx_busy        = r_busy;
   assign bus.packet_sent    = r_sent;
   assign bus.tx_error       = r_error;
   assign bus.fifo_count     = r_count;

endmodule

// File: tb/tb_hoplite_packet_tx_controller.sv
// Bench for hoplite_packet_tx_controller: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based packet model.
module tb_hoplite_packet_tx_controller;

   localparam int unsigned DEPTH = 8;

   logic clk;
   logic reset_n;

   hoplite_packet_tx_controller_if #(
      .COORD_BITS(1), .DATA_WIDTH(32), .FIFO_ADDR_BITS(3)
   ) bus ();

   hoplite_packet_tx_controller #(
      .COORD_BITS(1), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .FIFO_ADDR_BITS(3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: buffered words, destinations, sticky error, packet phase
   logic [31:0] m_q [$];
   logic        m_dx, m_dy, m_sx, m_sy, m_err;
   int          m_mode;   // 0 idle, 1 sending, 2 sent-report cycle
   logic [31:0] rx_q [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update();
      logic err;
      if (!reset_n) begin
         m_q.delete();
         m_dx = 0; m_dy = 0; m_sx = 0; m_sy = 0; m_err = 0; m_mode = 0;
      end else begin
         err = 0;
         if (bus.x_coord_in_valid) begin
            if (m_mode == 0) m_dx = bus.x_coord_in; else err = 1;
         end
         if (bus.y_coord_in_valid) begin
            if (m_mode == 0) m_dy = bus.y_coord_in; else err = 1;
         end
         if (bus.message_in_valid) begin
            if (m_mode == 0 && m_q.size() < DEPTH) m_q.push_back(bus.message_in);
            else err = 1;
         end
         case (m_mode)
            0: if (bus.packet_complete && m_q.size() > 0) begin
                  m_sx = m_dx; m_sy = m_dy; m_mode = 1;
               end
            1: if (bus.flit_out_ready) begin
                  void'(m_q.pop_front());
                  if (m_q.size() == 0) m_mode = 2;
               end
            default: m_mode = 0;
         endcase
         if (err) m_err = 1;
         else if (bus.error_clear) m_err = 0;
      end
   endtask

   task automatic compare();
      logic        sending;
      logic [31:0] head;
      sending = (m_mode == 1);
      head    = sending ? m_q[0] : 32'h0;
      check_eq("valid", 64'(bus.flit_out_valid), 64'(sending));
      check_eq("data",  64'(bus.flit_out_data),  64'(head));
      check_eq("last",  64'(bus.flit_out_last),  64'(sending && m_q.size() == 1));
      check_eq("x",     64'(bus.flit_out_x),     64'(sending ? m_sx : 1'b0));
      check_eq("y",     64'(bus.flit_out_y),     64'(sending ? m_sy : 1'b0));
      check_eq("busy",  64'(bus.tx_busy),        64'(m_mode != 0));
      check_eq("sent",  64'(bus.packet_sent),    64'(m_mode == 2));
      check_eq("error", 64'(bus.tx_error),       64'(m_err));
      check_eq("count", 64'(bus.fifo_count),     64'(m_q.size()));
   endtask

   // One clock: log a handshake, advance model on the edge, compare on the falling edge
   task automatic step();
      if (bus.flit_out_valid && bus.flit_out_ready) rx_q.push_back(bus.flit_out_data);
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
      bus.x_coord_in_valid = 0;
      bus.y_coord_in_valid = 0;
      bus.message_in_valid = 0;
      bus.packet_complete  = 0;
      bus.error_clear      = 0;
   endtask

   task automatic push(input logic [31:0] w);
      bus.message_in = w; bus.message_in_valid = 1; step();
   endtask

   task automatic set_dest(input logic x, input logic y);
      bus.x_coord_in = x; bus.x_coord_in_valid = 1;
      bus.y_coord_in = y; bus.y_coord_in_valid = 1;
      step();
   endtask

   initial begin
      reset_n = 0;
      bus.x_coord_in = 0; bus.x_coord_in_valid = 0;
      bus.y_coord_in = 0; bus.y_coord_in_valid = 0;
      bus.message_in = 0; bus.message_in_valid = 0;
      bus.packet_complete = 0; bus.error_clear = 0; bus.flit_out_ready = 0;
      m_mode = 0; m_dx = 0; m_dy = 0; m_sx = 0; m_sy = 0; m_err = 0;

      // Reset and idle
      @(negedge clk);
      repeat (3) step();
      reset_n = 1;
      step();
      check_eq("rst_count", 64'(bus.fifo_count), 64'd0);
      bus.packet_complete = 1; step();
      check_eq("empty_pc_valid", 64'(bus.flit_out_valid), 64'd0);
      check_eq("empty_pc_error", 64'(bus.tx_error), 64'd0);
      step();

      // Basic send with ready held high
      bus.flit_out_ready = 1;
      set_dest(1, 0);
      push(32'hDEADBEEF);
      push(32'h00000005);
      rx_q.delete();
      bus.packet_complete = 1; step();
      check_eq("b1_data", 64'(bus.flit_out_data), 64'hDEADBEEF);
      check_eq("b1_last", 64'(bus.flit_out_last), 64'd0);
      check_eq("b1_x",    64'(bus.flit_out_x), 64'd1);
      step();
      check_eq("b2_data", 64'(bus.flit_out_data), 64'h5);
      check_eq("b2_last", 64'(bus.flit_out_last), 64'd1);
      step();
      check_eq("b3_sent", 64'(bus.packet_sent), 64'd1);
      check_eq("b3_busy", 64'(bus.tx_busy), 64'd1);
      step();
      check_eq("b4_busy", 64'(bus.tx_busy), 64'd0);
      check_eq("b_rx_n",  64'(rx_q.size()), 64'd2);

      // Backpressure
      bus.flit_out_ready = 0;
      push(32'h11); push(32'h22); push(32'h33);
      rx_q.delete();
      bus.packet_complete = 1; step();
      begin
         logic [5:0] pat;
         pat = 6'b110100;   // applied LSB first: 0,0,1,0,1,1
         for (int i = 0; i < 6; i++) begin
            bus.flit_out_ready = pat[i];
            step();
         end
      end
      bus.flit_out_ready = 0;
      step();
      check_eq("bp_rx_n", 64'(rx_q.size()), 64'd3);
      if (rx_q.size() == 3) begin
         check_eq("bp_rx0", 64'(rx_q[0]), 64'h11);
         check_eq("bp_rx2", 64'(rx_q[2]), 64'h33);
      end

      // Overflow and pointer wrap
      for (int i = 1; i <= 9; i++) push(32'(i));
      check_eq("ovf_count", 64'(bus.fifo_count), 64'd8);
      check_eq("ovf_error", 64'(bus.tx_error), 64'd1);
      rx_q.delete();
      bus.packet_complete = 1; bus.flit_out_ready = 1; step();
      repeat (10) step();
      check_eq("ovf_rx_n", 64'(rx_q.size()), 64'd8);
      for (int i = 0; i < rx_q.size(); i++) check_eq("ovf_rx", 64'(rx_q[i]), 64'(i + 1));
      rx_q.delete();
      for (int i = 10; i <= 13; i++) push(32'(i));
      bus.packet_complete = 1; step();
      repeat (6) step();
      check_eq("wrap_rx_n", 64'(rx_q.size()), 64'd4);
      for (int i = 0; i < rx_q.size(); i++) check_eq("wrap_rx", 64'(rx_q[i]), 64'(i + 10));
      bus.error_clear = 1; step();
      check_eq("clr_error", 64'(bus.tx_error), 64'd0);

      // Writes during SEND are dropped
      bus.flit_out_ready = 0;
      set_dest(1, 1);
      push(32'h55); push(32'h66);
      rx_q.delete();
      bus.packet_complete = 1; step();
      bus.message_in = 32'hAA; bus.message_in_valid = 1;
      bus.x_coord_in = 0; bus.x_coord_in_valid = 1;
      step();
      check_eq("ws_error", 64'(bus.tx_error), 64'd1);
      check_eq("ws_x",     64'(bus.flit_out_x), 64'd1);
      check_eq("ws_count", 64'(bus.fifo_count), 64'd2);
      bus.flit_out_ready = 1;
      repeat (4) step();
      check_eq("ws_rx_n", 64'(rx_q.size()), 64'd2);
      bus.error_clear = 1; step();

      // Reset mid-packet
      bus.flit_out_ready = 0;
      for (int i = 0; i < 4; i++) push(32'h100 + 32'(i));
      bus.packet_complete = 1; step();
      bus.flit_out_ready = 1; step();
      reset_n = 0; bus.flit_out_ready = 0; step();
      check_eq("mr_valid", 64'(bus.flit_out_valid), 64'd0);
      check_eq("mr_count", 64'(bus.fifo_count), 64'd0);
      reset_n = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("mr_sent", 64'(bus.packet_sent), 64'd0);
      end

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         reset_n              = ($urandom_range(0, 199) != 0);
         bus.x_coord_in       = 1'($urandom_range(0, 1));
         bus.y_coord_in       = 1'($urandom_range(0, 1));
         bus.x_coord_in_valid = ($urandom_range(0, 9) == 0);
         bus.y_coord_in_valid = ($urandom_range(0, 9) == 0);
         bus.message_in       = $urandom;
         bus.message_in_valid = ($urandom_range(0, 9) < 4);
         bus.packet_complete  = ($urandom_range(0, 9) == 0);
         bus.error_clear      = ($urandom_range(0, 19) == 0);
         bus.flit_out_ready   = ($urandom_range(0, 9) < 6);
         step();
      end
      reset_n = 1; bus.flit_out_ready = 1;
      repeat (12) step();
      check_eq("final_busy", 64'(bus.tx_busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
